// File: rtl/alu_lfsr_display_if.sv
// Bundle of step-request and display signals for alu_lfsr_display.
// The master drives operands and the step strobe; the slave returns
// the registered result, its flags and the seven-segment outputs.
interface alu_lfsr_display_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             mode;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             valid;
    logic [6:0]       seg;
    logic [1:0]       dig_sel;

    modport master (
        output en, a, b, op, mode,
        input  result, carry, zero, valid, seg, dig_sel
    );

    modport slave (
        input  en, a, b, op, mode,
        output result, carry, zero, valid, seg, dig_sel
    );
endinterface

// File: rtl/alu_lfsr_display.sv
// WIDTH-bit ALU / Fibonacci LFSR with a registered result that drives a
// time-multiplexed hex seven-segment display (one or two digits).
module alu_lfsr_display #(
    parameter int         WIDTH       = 4,
    parameter logic [7:0] LFSR_TAPS   = 8'h0C,
    parameter logic [7:0] LFSR_SEED   = 8'h01,
    parameter int         REFRESH_DIV = 1024
) (
    input logic              clk,
    input logic              rst,
    alu_lfsr_display_if.slave bus
);
    localparam int DIGITS = (WIDTH + 3) / 4;

    // A zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_RAW = LFSR_SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED     = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;
    localparam logic [WIDTH-1:0] TAPS     = LFSR_TAPS[WIDTH-1:0];

    localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             valid_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [CNT_W-1:0] refresh_cnt;
    logic             digit_idx;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] lfsr_next;
    logic [7:0]       result_ext;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;

    // ALU datapath: one extra bit on add/sub exposes carry and borrow.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        alu_res   = '0;
        alu_carry = 1'b0;
        sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
        diff_ext  = {1'b0, bus.a} - {1'b0, bus.b};
        case (op_e'(bus.op))
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            default: alu_res = '0;
        endcase
    end

    // LFSR successor; an all-zero state is recovered by reloading the seed.
    always_comb begin
        lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        if (lfsr_q == '0) begin
            lfsr_next = SEED;
        end
    end

    // Step registers: result, flags and LFSR state advance on an accepted strobe.
    always_ff @(posedge clk) begin
        // NOTE: state is assigned non-blocking so every register samples pre-edge values.
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            lfsr_q   <= SEED;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                if (bus.mode) begin
                    lfsr_q   <= lfsr_next;
                    result_q <= lfsr_next;
                    carry_q  <= 1'b0;
                end else begin
                    result_q <= alu_res;
                    carry_q  <= alu_carry;
                end
            end
        end
    end

    // Refresh timer: each digit stays lit for REFRESH_DIV cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 1'b0;
        end else if (refresh_cnt == CNT_MAX) begin
            refresh_cnt <= '0;
            if (DIGITS > 1) begin
                digit_idx <= ~digit_idx;
            end
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Hex decode of the selected nibble; purely combinational from registers,
    // so a digit switch or result update never shows an intermediate value.
    always_comb begin
        result_ext = 8'(result_q);
        nibble     = digit_idx ? result_ext[7:4] : result_ext[3:0];
        case (nibble)
            4'h0:    seg_dec = 7'b0111111;
            4'h1:    seg_dec = 7'b0000110;
            4'h2:    seg_dec = 7'b1011011;
            4'h3:    seg_dec = 7'b1001111;
            4'h4:    seg_dec = 7'b1100110;
            4'h5:    seg_dec = 7'b1101101;
            4'h6:    seg_dec = 7'b1111101;
            4'h7:    seg_dec = 7'b0000111;
            4'h8:    seg_dec = 7'b1111111;
            4'h9:    seg_dec = 7'b1101111;
            4'hA:    seg_dec = 7'b1110111;
            4'hB:    seg_dec = 7'b1111100;
            4'hC:    seg_dec = 7'b0111001;
            4'hD:    seg_dec = 7'b1011110;
            4'hE:    seg_dec = 7'b1111001;
            default: seg_dec = 7'b1110001;
        endcase
    end

    assign bus.result  = result_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = (result_q == '0);
    assign bus.valid   = valid_q;
    assign bus.seg     = seg_dec;
    assign bus.dig_sel = digit_idx ? 2'b10 : 2'b01;
endmodule

// File: tb/tb_alu_lfsr_display.sv
// Self-checking bench: a 4-bit single-digit instance and an 8-bit
// two-digit instance, directed vector tables plus random stimulus
// compared against an arithmetic reference model.
module tb_alu_lfsr_display;
    logic clk = 1'b0;
    logic rst4, rst8;

    always #5 clk = ~clk;

    alu_lfsr_display_if #(.WIDTH(4)) bus4 ();
    alu_lfsr_display_if #(.WIDTH(8)) bus8 ();

    alu_lfsr_display #(.WIDTH(4), .LFSR_TAPS(8'h0C), .LFSR_SEED(8'h01), .REFRESH_DIV(3))
        dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));

    alu_lfsr_display #(.WIDTH(8), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h00), .REFRESH_DIV(4))
        dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));

    int n_vec  = 0;
    int n_fail = 0;

    // Segment patterns for hex digits 0..F.
    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference model state for one instance.
    typedef struct {
        int result;
        bit carry;
        bit valid;
        int lfsr;
        int cyc;
    } model_t;

    model_t m4, m8;

    function automatic model_t model_step(model_t m, int w, int taps, int seed,
                                          bit rst, bit en, int a, int b, int op, bit mode);
        model_t n = m;
        int modv = 1 << w;
        int s;
        if (rst) begin
            n.result = 0; n.carry = 0; n.valid = 0; n.cyc = 0;
            n.lfsr = ((seed % modv) == 0) ? 1 : (seed % modv);
            return n;
        end
        n.cyc   = m.cyc + 1;
        n.valid = en;
        if (!en) return n;
        if (mode) begin
            if (m.lfsr == 0) begin
                s = ((seed % modv) == 0) ? 1 : (seed % modv);
            end else begin
                s = (m.lfsr * 2 + ($countones(m.lfsr & taps & (modv - 1)) % 2)) % modv;
            end
            n.lfsr = s; n.result = s; n.carry = 0;
        end else begin
            case (op)
                0: begin n.result = (a + b) % modv;        n.carry = (a + b) >= modv; end
                1: begin n.result = (a - b + modv) % modv; n.carry = a < b;           end
                2: begin n.result = a & b;                 n.carry = 0;               end
                default: begin n.result = a | b;           n.carry = 0;               end
            endcase
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance one clock edge, stepping both models with the inputs present at it.
    task automatic tick();
        m4 = model_step(m4, 4, 'h0C, 'h01, rst4, bus4.en, int'(bus4.a), int'(bus4.b), int'(bus4.op), bus4.mode);
        m8 = model_step(m8, 8, 'hB8, 'h00, rst8, bus8.en, int'(bus8.a), int'(bus8.b), int'(bus8.op), bus8.mode);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model4(input string tag);
        check({tag, " w4 result"},  32'(bus4.result),  32'(m4.result));
        check({tag, " w4 carry"},   32'(bus4.carry),   32'(m4.carry));
        check({tag, " w4 zero"},    32'(bus4.zero),    32'(m4.result == 0));
        check({tag, " w4 valid"},   32'(bus4.valid),   32'(m4.valid));
        check({tag, " w4 seg"},     32'(bus4.seg),     32'(seg_tab[m4.result % 16]));
        check({tag, " w4 dig_sel"}, 32'(bus4.dig_sel), 32'h1);
    endtask

    task automatic check_model8(input string tag);
        int idx = (m8.cyc / 4) % 2;
        check({tag, " w8 result"},  32'(bus8.result),  32'(m8.result));
        check({tag, " w8 carry"},   32'(bus8.carry),   32'(m8.carry));
        check({tag, " w8 zero"},    32'(bus8.zero),    32'(m8.result == 0));
        check({tag, " w8 valid"},   32'(bus8.valid),   32'(m8.valid));
        check({tag, " w8 seg"},     32'(bus8.seg),     32'(seg_tab[(m8.result >> (4 * idx)) % 16]));
        check({tag, " w8 dig_sel"}, 32'(bus8.dig_sel), 32'(1 << idx));
    endtask

    task automatic reset4();
        rst4 = 1'b1; tick(); rst4 = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       carry;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [8];

    int lfsr_seq [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

    initial begin
        vecs[0] = '{2'b00, 4'h9, 4'h8, 4'h1, 1'b1, 7'b0000110};
        vecs[1] = '{2'b01, 4'h3, 4'h5, 4'hE, 1'b1, 7'b1111001};
        vecs[2] = '{2'b01, 4'h5, 4'h5, 4'h0, 1'b0, 7'b0111111};
        vecs[3] = '{2'b10, 4'hC, 4'hA, 4'h8, 1'b0, 7'b1111111};
        vecs[4] = '{2'b11, 4'h5, 4'hA, 4'hF, 1'b0, 7'b1110001};
        vecs[5] = '{2'b00, 4'h7, 4'h8, 4'hF, 1'b0, 7'b1110001};
        vecs[6] = '{2'b01, 4'hF, 4'h1, 4'hE, 1'b0, 7'b1111001};
        vecs[7] = '{2'b00, 4'h3, 4'h3, 4'h6, 1'b0, 7'b1111101};

        bus4.en = 0; bus4.a = 0; bus4.b = 0; bus4.op = 0; bus4.mode = 0;
        bus8.en = 0; bus8.a = 0; bus8.b = 0; bus8.op = 0; bus8.mode = 0;
        rst4 = 1'b1; rst8 = 1'b1;
        m4 = '{0, 0, 0, 1, 0};
        m8 = '{0, 0, 0, 1, 0};
        tick(); tick();
        rst4 = 1'b0; rst8 = 1'b0;

        // Reset values on both instances.
        check("rst w4 result", 32'(bus4.result), 32'h0);
        check("rst w4 carry", 32'(bus4.carry), 32'h0);
        check("rst w4 zero", 32'(bus4.zero), 32'h1);
        check("rst w4 valid", 32'(bus4.valid), 32'h0);
        check("rst w4 seg", 32'(bus4.seg), 32'b0111111);
        check("rst w4 dig_sel", 32'(bus4.dig_sel), 32'h1);
        check("rst w8 dig_sel", 32'(bus8.dig_sel), 32'h1);
        check("rst w8 seg", 32'(bus8.seg), 32'b0111111);

        // Directed ALU table: each step followed by an idle cycle with scrambled inputs.
        foreach (vecs[i]) begin
            bus4.en = 1; bus4.mode = 0;
            bus4.op = vecs[i].op; bus4.a = vecs[i].a; bus4.b = vecs[i].b;
            tick();
            check($sformatf("vec%0d result", i), 32'(bus4.result), 32'(vecs[i].res));
            check($sformatf("vec%0d carry", i), 32'(bus4.carry), 32'(vecs[i].carry));
            check($sformatf("vec%0d zero", i), 32'(bus4.zero), 32'(vecs[i].res == 4'h0));
            check($sformatf("vec%0d valid", i), 32'(bus4.valid), 32'h1);
            check($sformatf("vec%0d seg", i), 32'(bus4.seg), 32'(vecs[i].seg));
            bus4.en = 0; bus4.a = 4'($urandom); bus4.b = 4'($urandom);
            bus4.op = 2'($urandom); bus4.mode = 1'($urandom);
            tick();
            check($sformatf("vec%0d idle valid", i), 32'(bus4.valid), 32'h0);
            check($sformatf("vec%0d idle hold", i), 32'(bus4.result), 32'(vecs[i].res));
            check($sformatf("vec%0d idle carry", i), 32'(bus4.carry), 32'(vecs[i].carry));
        end

        // LFSR period: back-to-back steps, with a 3-cycle pause after the sixth.
        reset4();
        for (int i = 0; i < 15; i++) begin
            bus4.en = 1; bus4.mode = 1;
            tick();
            check($sformatf("lfsr step%0d", i), 32'(bus4.result), 32'(lfsr_seq[i]));
            check($sformatf("lfsr valid%0d", i), 32'(bus4.valid), 32'h1);
            check($sformatf("lfsr nonzero%0d", i), 32'(bus4.zero), 32'h0);
            if (i == 5) begin
                for (int k = 0; k < 3; k++) begin
                    bus4.en = 0; bus4.a = 4'($urandom); bus4.op = 2'($urandom);
                    tick();
                    check($sformatf("lfsr pause hold%0d", k), 32'(bus4.result), 32'(lfsr_seq[5]));
                    check($sformatf("lfsr pause valid%0d", k), 32'(bus4.valid), 32'h0);
                end
            end
        end
        // Wraps back to the start of the sequence.
        tick();
        check("lfsr wrap", 32'(bus4.result), 32'h2);

        // Reset mid-sequence while a step is requested.
        reset4();
        bus4.en = 1; bus4.mode = 1;
        for (int i = 0; i < 5; i++) tick();
        check("pre-rst lfsr", 32'(bus4.result), 32'h6);
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        check("midrst result", 32'(bus4.result), 32'h0);
        check("midrst valid", 32'(bus4.valid), 32'h0);
        check("midrst zero", 32'(bus4.zero), 32'h1);
        check("midrst seg", 32'(bus4.seg), 32'b0111111);
        tick();
        check("post-rst lfsr", 32'(bus4.result), 32'h2);

        // Interleaved ALU / LFSR steps: the ALU step leaves the LFSR untouched.
        bus4.en = 0;
        reset4();
        bus4.en = 1; bus4.mode = 0; bus4.op = 2'b00; bus4.a = 4'h1; bus4.b = 4'h1;
        tick();
        check("mix add", 32'(bus4.result), 32'h2);
        bus4.mode = 1;
        tick();
        check("mix lfsr", 32'(bus4.result), 32'h2);
        bus4.mode = 0; bus4.op = 2'b11; bus4.a = 4'h3; bus4.b = 4'h4;
        tick();
        check("mix or", 32'(bus4.result), 32'h7);
        check("mix or carry", 32'(bus4.carry), 32'h0);
        bus4.en = 0;

        // Two-digit display: 0x5A alternates "A" / "5" every four cycles.
        bus8.en = 1; bus8.mode = 0; bus8.op = 2'b00; bus8.a = 8'h5A; bus8.b = 8'h00;
        tick();
        bus8.en = 0;
        check("disp result", 32'(bus8.result), 32'h5A);
        for (int i = 0; i < 16; i++) begin
            check_model8($sformatf("disp%0d", i));
            check($sformatf("disp%0d digit", i), 32'(bus8.seg),
                  (bus8.dig_sel == 2'b01) ? 32'b1110111 : 32'b1101101);
            tick();
        end
        bus8.en = 1; bus8.a = 8'hFF; bus8.b = 8'h01;
        tick();
        bus8.en = 0;
        check("w8 wrap result", 32'(bus8.result), 32'h0);
        check("w8 wrap carry", 32'(bus8.carry), 32'h1);
        check("w8 wrap zero", 32'(bus8.zero), 32'h1);

        // Random stimulus on both instances against the reference model.
        for (int i = 0; i < 400; i++) begin
            rst4 = ($urandom_range(0, 49) == 0);
            rst8 = ($urandom_range(0, 49) == 0);
            bus4.en = 1'($urandom); bus4.mode = ($urandom_range(0, 3) == 0);
            bus4.op = 2'($urandom); bus4.a = 4'($urandom); bus4.b = 4'($urandom);
            bus8.en = 1'($urandom); bus8.mode = ($urandom_range(0, 3) == 0);
            bus8.op = 2'($urandom); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            tick();
            check_model4($sformatf("rnd%0d", i));
            check_model8($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_lfsr_display.md
Name: alu_lfsr_display

Overview:
Parametrised successor to the team's 2-bit ALU/LFSR seven-segment demo block. It adds two WIDTH-bit operands, or performs another selected operation on them. Alternatively it steps a WIDTH-bit Fibonacci LFSR. The registered result drives a time-multiplexed hex seven-segment display. It sits directly behind the ui_in/uo_out pins of a TinyTapeout tile wrapper.

Parameters:
WIDTH, 4, operand/result/LFSR width; legal range 2..8.
LFSR_TAPS, 8'h0C, feedback tap mask; only the low WIDTH bits are used. Default gives x^4+x^3+1.
LFSR_SEED, 8'h01, reset/recovery state; only the low WIDTH bits are used. A value of 0 is treated as 1.
REFRESH_DIV, 1024, clock cycles each digit is shown; must be >= 1.
DIGITS, (WIDTH+3)/4, derived localparam, not overridable; value is 1 or 2.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  step strobe; samples a, b, op and mode this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  2  00 add, 01 sub (a-b), 10 and, 11 or
mode  in  1  0 = ALU, 1 = LFSR
result  out  WIDTH  registered result
carry  out  1  add carry-out / sub borrow
zero  out  1  high when result == 0
valid  out  1  one-cycle pulse, one cycle after an accepted step
seg  out  7  active-high segments; bit0=a ... bit6=g
dig_sel  out  2  one-hot digit enable, active high

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. rst has priority over en.
- Reset values:
  - result=0, carry=0, zero=1, valid=0
  - lfsr=LFSR_SEED (with 0 treated as 1)
  - refresh counter=0, digit index=0
  - dig_sel=2'b01, seg=7'b0111111 (digit "0")
- Step, when en=1 and rst=0; registered outputs update on that edge and valid=1 in the following cycle:
  - mode=0: result <= op(a,b), computed mod 2^WIDTH.
    - add: carry = bit WIDTH of a+b.
    - sub: carry = 1 iff a<b (unsigned).
    - and/or: carry=0.
    - The LFSR holds its state.
  - mode=1: next = {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS[WIDTH-1:0])}.
    - lfsr <= next and result <= next; carry=0.
    - If lfsr==0 (corruption), next = seed instead.
- zero is combinational from the registered result.
- en=0: result, carry, lfsr and zero hold; valid=0. Changes on a, b, op or mode have no effect.
- Back-to-back en is legal: one step per cycle, and valid stays high.
- Display:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap it returns to 0 and the digit index advances modulo DIGITS.
  - Digit d shows nibble result[4d+3:4d], zero-extended when WIDTH is not a multiple of 4.
  - seg is a combinational hex decode of the current nibble:
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
    - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - dig_sel = one-hot(digit index). With DIGITS=1 it is constant 2'b01 and the counter has no visible effect.
  - The display reflects result updates in the same cycle result changes. A digit switch never glitches through an intermediate value.
- Reset mid-operation: all state returns to reset values on that edge. Any in-flight valid is dropped. The LFSR sequence restarts from the seed.
- RTL holds no internal state beyond: result, carry, valid, lfsr, refresh counter, digit index.

Test Plan:
1. WIDTH=4. Reset, then en with mode=0, op=00, a=9, b=8. Next cycle: result=1, carry=1, zero=0, valid=1, seg=0000110. Following cycle with en=0: valid=0.
2. WIDTH=4. Sub 3-5: result=0xE, carry=1, seg=1111001. Then sub 5-5: result=0, carry=0, zero=1, seg=0111111. Then and 0xC,0xA: result=8, carry=0.
3. WIDTH=4, default taps and seed. Hold mode=1, en=1. Results must be 2,4,9,3,6,D,A,5,B,7,F,E,C,8,1: period 15, never 0. Drop en for 3 cycles mid-sequence: sequence resumes unchanged.
4. WIDTH=8, REFRESH_DIV=4. After add 0x5A+0x00: dig_sel is 01 with seg=1110111 ("A") for 4 cycles, then 10 with seg=1101101 ("5") for 4 cycles, alternating. Add 0xFF+0x01: result=0, carry=1.
5. Assert rst in the same cycle as en with mode=1 after 5 LFSR steps. Outputs go to reset values, valid=0. The next LFSR step yields 2.
6. Interleave steps: ALU add 1+1, then LFSR step, then ALU or 0x3|0x4. LFSR yields 2, i.e. it was unaffected by the preceding ALU step. Final result=7.
